// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// controller state encoding, largest displayable value and BCD digit width.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEC_MAX = 9999;
    localparam int BCD_W   = 4;

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// bcd_digit_adj: double-dabble correction for one BCD digit.
// Adds 3 to any digit of 5 or more so the following left shift carries
// correctly into the next decimal digit. Purely combinational.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q
);

    // add-3 correction ahead of the shift
    always_comb begin
        q = d;
        if (d >= BCD_W'(5)) begin
            q = d + BCD_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: multi-cycle double-dabble binary-to-BCD converter with a
// valid/ready handshake on both sides. One input bit is consumed per SHIFT
// cycle; the four BCD digits and the overflow flag are registered on the
// edge that enters DONE and then held until the next result, so a display
// fed from them never blanks.
// Build option: define BIN2BCD_SAT_EN to show 9999 whenever the captured
// value exceeds 9999; without it the display shows the value mod 10000.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BCD_W-1:0] digit_1,
    output logic [BCD_W-1:0] digit_10,
    output logic [BCD_W-1:0] digit_100,
    output logic [BCD_W-1:0] digit_1000,
    output logic             overflow
);

    localparam int BCD_TOT = DIGITS * BCD_W;
    localparam int OUT_TOT = 4 * BCD_W;
    localparam int CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;

`ifdef BIN2BCD_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   bin_sh;
    logic [BIN_W-1:0]   bin_sh_nxt;
    logic [BCD_TOT-1:0] bcd_acc;
    logic [BCD_TOT-1:0] bcd_adj;
    logic [BCD_TOT-1:0] bcd_nxt;
    logic               ovf_cap;
    logic               accept;
    logic               last_shift;

    // Saturate the displayed digits to 9999 when enabled and out of range.
    function automatic logic [OUT_TOT-1:0] sat_digits(input logic [OUT_TOT-1:0] raw,
                                                      input logic ovf);
        if (SAT_EN && ovf) begin
            return {4{BCD_W'(9)}};
        end
        return raw;
    endfunction

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .d (bcd_acc[g*BCD_W +: BCD_W]),
                .q (bcd_adj[g*BCD_W +: BCD_W])
            );
        end
    endgenerate

    // Carry out of the top digit falls off the left end of the shift.
    assign bcd_nxt    = (bcd_adj << 1) | BCD_TOT'(bin_sh[BIN_W-1]);
    assign bin_sh_nxt = bin_sh << 1;

    assign accept     = in_valid && (state == IDLE);
    assign last_shift = (state == SHIFT) && (cnt == '0);
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);

    // next-state logic for the handshake/conversion controller
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = SHIFT;
            SHIFT:   if (cnt == '0)  state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // shift counter and overflow flag captured alongside the input value
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            ovf_cap <= 1'b0;
        end else if (accept) begin
            cnt     <= CNT_W'(BIN_W - 1);
            ovf_cap <= (32'(bin) > 32'(DEC_MAX));
        end else if ((state == SHIFT) && (cnt != '0)) begin
            cnt     <= cnt - 1'b1;
        end
    end

    // working shift registers; only meaningful between accept and DONE
    always_ff @(posedge clk) begin
        if (accept) begin
            bin_sh  <= bin;
            bcd_acc <= '0;
        end else if (state == SHIFT) begin
            bin_sh  <= bin_sh_nxt;
            bcd_acc <= bcd_nxt;
        end
    end

    // result registers, loaded only on the edge that enters DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            {digit_1000, digit_100, digit_10, digit_1} <= '0;
            overflow <= 1'b0;
        end else if (last_shift) begin
            {digit_1000, digit_100, digit_10, digit_1} <=
                sat_digits(bcd_nxt[OUT_TOT-1:0], ovf_cap);
            overflow <= ovf_cap;
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: expected results are queued when a
// value is accepted and compared when out_valid appears. Honours
// BIN2BCD_SAT_EN the same way as the design build.
module tb_bin2bcd_seq;

    localparam int BIN_W = 14;
    localparam int LAT   = BIN_W + 1;

    typedef struct packed {
        logic       ovf;
        logic [3:0] d1000;
        logic [3:0] d100;
        logic [3:0] d10;
        logic [3:0] d1;
    } res_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [BIN_W-1:0] bin = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       digit_1, digit_10, digit_100, digit_1000;
    logic             overflow;

    int   vec_cnt = 0;
    int   err_cnt = 0;
    res_t exp_q[$];
    res_t last_res = '0;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bin        (bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .digit_1    (digit_1),
        .digit_10   (digit_10),
        .digit_100  (digit_100),
        .digit_1000 (digit_1000),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input int v);
        res_t r;
        int   m;
        m = v % 10000;
`ifdef BIN2BCD_SAT_EN
        if (v > 9999) m = 9999;
`endif
        r.ovf   = (v > 9999);
        r.d1000 = 4'(m / 1000);
        r.d100  = 4'((m / 100) % 10);
        r.d10   = 4'((m / 10) % 10);
        r.d1    = 4'(m % 10);
        return r;
    endfunction

    function automatic res_t observed();
        return {overflow, digit_1000, digit_100, digit_10, digit_1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present v until accepted (bounded); queue its expected result.
    task automatic accept_one(input int v, output bit ok);
        ok       = 1'b0;
        bin      = BIN_W'(v);
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (ok) exp_q.push_back(model(v));
    endtask

    // Count edges (starting from 'start') until out_valid, bounded.
    task automatic wait_out(input int start, output int lat);
        lat = start;
        while (out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    function automatic res_t pop_exp();
        if (exp_q.size() == 0) return '1;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vec_cnt++;
        if ({in_ready, out_valid, observed()} !== {1'b1, 1'b0, 17'd0}) begin
            err_cnt++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h, expected rdy=1 vld=0 res=0",
                     in_ready, out_valid, observed());
        end
    endtask

    task automatic test_basic(input int v);
        bit   ok;
        int   lat;
        res_t e;
        accept_one(v, ok);
        wait_out(1, lat);
        vec_cnt++;
        if (!ok || lat != LAT) begin
            err_cnt++;
            $display("FAIL basic_latency(%0d): got accepted=%b lat=%0d, expected lat=%0d", v, ok, lat, LAT);
        end
        e = pop_exp();
        vec_cnt++;
        if (observed() !== e) begin
            err_cnt++;
            $display("FAIL basic_result(%0d): got %h expected %h", v, observed(), e);
        end
        out_ready = 1'b1;
        vec_cnt++;
        if (in_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_no_same_cycle(%0d): got in_ready=%b expected 0", v, in_ready);
        end
        tick();
        out_ready = 1'b0;
        vec_cnt++;
        if ({in_ready, out_valid, observed()} !== {1'b1, 1'b0, e}) begin
            err_cnt++;
            $display("FAIL basic_idle_hold(%0d): got rdy=%b vld=%b res=%h, expected rdy=1 vld=0 res=%h",
                     v, in_ready, out_valid, observed(), e);
        end
        last_res = e;
    endtask

    task automatic test_overflow();
        bit   ok;
        int   lat;
        res_t e;
        accept_one(12345, ok);
        repeat (4) tick();
        // in SHIFT: previous result still shown, stray in_valid ignored
        vec_cnt++;
        if ({in_ready, out_valid, observed()} !== {1'b0, 1'b0, last_res}) begin
            err_cnt++;
            $display("FAIL ovf_midshift_hold: got rdy=%b vld=%b res=%h, expected rdy=0 vld=0 res=%h",
                     in_ready, out_valid, observed(), last_res);
        end
        bin      = BIN_W'(7777);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(6, lat);
        vec_cnt++;
        if (!ok || lat != LAT) begin
            err_cnt++;
            $display("FAIL ovf_latency: got accepted=%b lat=%0d, expected lat=%0d", ok, lat, LAT);
        end
        e = pop_exp();
        vec_cnt++;
        if (observed() !== e) begin
            err_cnt++;
            $display("FAIL ovf_result: got %h expected %h", observed(), e);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        last_res = e;
    endtask

    task automatic test_hold();
        bit   ok;
        int   lat;
        int   bad;
        res_t e;
        accept_one(9999, ok);
        wait_out(1, lat);
        e = pop_exp();
        vec_cnt++;
        if (!ok || lat != LAT) begin
            err_cnt++;
            $display("FAIL hold_latency: got accepted=%b lat=%0d, expected lat=%0d", ok, lat, LAT);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if ({out_valid, in_ready, observed()} !== {1'b1, 1'b0, e}) bad++;
            tick();
        end
        vec_cnt++;
        if (bad != 0) begin
            err_cnt++;
            $display("FAIL hold_stall: got %0d bad cycles of 20, expected 0 (last res=%h vld=%b rdy=%b, expected %h)",
                     bad, observed(), out_valid, in_ready, e);
        end
        out_ready = 1'b1;
        vec_cnt++;
        if (in_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL hold_release_same: got in_ready=%b expected 0", in_ready);
        end
        tick();
        out_ready = 1'b0;
        vec_cnt++;
        if ({in_ready, out_valid} !== 2'b10) begin
            err_cnt++;
            $display("FAIL hold_release_next: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
        last_res = e;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        int bad;
        accept_one(5678, ok);
        if (ok) void'(exp_q.pop_back());
        repeat (6) tick();   // now in SHIFT cycle 7
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vec_cnt++;
        if ({in_ready, out_valid, observed()} !== {1'b1, 1'b0, 17'd0}) begin
            err_cnt++;
            $display("FAIL reset_midshift: got rdy=%b vld=%b res=%h, expected rdy=1 vld=0 res=0",
                     in_ready, out_valid, observed());
        end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid !== 1'b0 || observed() === model(5678) || !ok) bad++;
            tick();
        end
        vec_cnt++;
        if (bad != 0) begin
            err_cnt++;
            $display("FAIL reset_no_partial: got %0d bad cycles, expected 0", bad);
        end
        // abort while sitting in DONE
        accept_one(3, ok);
        wait_out(1, lat);
        if (ok) void'(exp_q.pop_back());
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vec_cnt++;
        if ({lat == LAT, in_ready, out_valid, observed()} !== {1'b1, 1'b1, 1'b0, 17'd0}) begin
            err_cnt++;
            $display("FAIL reset_middone: got lat=%0d rdy=%b vld=%b res=%h, expected lat=%0d rdy=1 vld=0 res=0",
                     lat, in_ready, out_valid, observed(), LAT);
        end
        last_res = '0;
    endtask

    task automatic test_back_to_back();
        int   lat;
        int   early;
        res_t e;
        bin      = BIN_W'(42);
        in_valid = 1'b1;
        vec_cnt++;
        if (in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_first_ready: got in_ready=%b expected 1", in_ready);
        end
        exp_q.push_back(model(42));
        tick();
        bin = BIN_W'(8000);  // in_valid stays high throughout
        exp_q.push_back(model(8000));
        early = 0;
        lat   = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) early++;
            tick();
            lat++;
        end
        e = pop_exp();
        vec_cnt++;
        if ({lat == LAT, early == 0, observed()} !== {1'b1, 1'b1, e}) begin
            err_cnt++;
            $display("FAIL b2b_first: got lat=%0d early_ready=%0d res=%h, expected lat=%0d early_ready=0 res=%h",
                     lat, early, observed(), LAT, e);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vec_cnt++;
        if (in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_second_ready: got in_ready=%b expected 1", in_ready);
        end
        tick();              // second value accepted here
        in_valid = 1'b0;
        wait_out(1, lat);
        e = pop_exp();
        vec_cnt++;
        if ({lat == LAT, observed()} !== {1'b1, e}) begin
            err_cnt++;
            $display("FAIL b2b_second: got lat=%0d res=%h, expected lat=%0d res=%h", lat, observed(), LAT, e);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic(0);
        test_basic(1234);
        test_overflow();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_basic(16383);
        test_basic(10000);
        for (int i = 0; i < 5; i++) begin
            test_basic(int'($urandom_range(0, 16383)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 14, meaning binary input width.
REQ-002 SHALL have parameter DIGITS, default 4, meaning number of BCD output digits.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  bin is presented for conversion.
REQ-006 SHALL have port in_ready  output  1  block accepts a new value this cycle.
REQ-007 SHALL have port bin  input  BIN_W  unsigned binary value from the FND number register.
REQ-008 SHALL have port out_valid  output  1  conversion result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port digit_1, digit_10, digit_100, digit_1000  output  4 each  BCD digits feeding the digit mux.
REQ-011 SHALL have port overflow  output  1  last accepted bin exceeded 9999.

Function
REQ-012 SHALL use FSM states IDLE, SHIFT, DONE, where SHIFT runs double-dabble (add-3 to any digit >=5, then shift left one bit).
REQ-013 SHALL drive in_ready=1 only in IDLE and capture bin on in_valid&&in_ready, then enter SHIFT.
REQ-014 SHALL spend exactly BIN_W cycles in SHIFT (counter BIN_W-1 down to 0), then enter DONE.
REQ-015 SHALL assert out_valid in DONE only, i.e. BIN_W+1 cycles after the accept edge (15 cycles at default).
REQ-016 SHALL hold out_valid and all outputs stable while out_ready=0, with no timeout.
REQ-017 SHALL return DONE to IDLE on out_ready=1, so in_ready rises the following cycle (no same-cycle re-accept).
REQ-018 SHALL update digit_* and overflow only on the DONE entry edge, and SHALL hold the last result through IDLE/SHIFT so the display never blanks.
REQ-019 SHALL set overflow=1 iff the captured bin > 9999; this comparison SHALL be made at capture.
REQ-020 SHALL ignore in_valid outside IDLE, leaving captured data unaffected.
REQ-021 SHALL discard carries out of digit_1000 during shifting (result = bin mod 10000 when not saturating).

Reset
REQ-022 SHALL, on reset, force state IDLE, shift counter 0, digit_*=0, overflow=0, out_valid=0, in_ready=1 on the next cycle.
REQ-023 SHALL abort any conversion in progress on reset mid-SHIFT or mid-DONE, leaving no partial result visible.

Configuration
REQ-024 SHALL, with BIN2BCD_SAT_EN defined, output digits 9,9,9,9 when overflow=1.
REQ-025 SHALL, without BIN2BCD_SAT_EN, output bin mod 10000 digits when overflow=1; overflow behaviour and latency SHALL be identical in both builds.

Structure
REQ-026 SHALL place the state enum (IDLE/SHIFT/DONE), DEC_MAX=9999 and BCD digit width 4 in shared package bin2bcd_pkg.
REQ-027 SHALL implement the per-digit add-3 correction as sub-module bcd_digit_adj (4-bit in, 4-bit out, combinational), instantiated DIGITS times.

Verification
REQ-028 SHALL verify: bin=0, in_valid 1 cycle -> out_valid at +15 cycles, digits 0,0,0,0, overflow=0.
REQ-029 SHALL verify: bin=1234 -> digit_1000=1, digit_100=2, digit_10=3, digit_1=4, overflow=0, latency 15.
REQ-030 SHALL verify: bin=12345 -> overflow=1; digits 9,9,9,9 with BIN2BCD_SAT_EN, digits 2,3,4,5 without.
REQ-031 SHALL verify: bin=9999 with out_ready=0 for 20 cycles -> out_valid and digits 9,9,9,9 held, in_ready=0; out_ready=1 -> in_ready=1 next cycle.
REQ-032 SHALL verify: reset asserted at SHIFT cycle 7 of bin=5678 -> next cycle outputs zero, out_valid=0, in_ready=1, no 5678 ever appears.
REQ-033 SHALL verify: back-to-back 42 then 8000 with in_valid held high -> second accepted only after first handshake; results 0042 then 8000.
